period_meter: RTL and testbench

- Receive-side companion to the team's clock divider. Measures the period of a slow, asynchronous square wave `sig_in`, such as a divided clock, in `clk` cycles.
- Reports each completed period with a one-cycle valid strobe.
- Declares lock when consecutive periods agree within a tolerance.
- Flags a timeout when edges stop arriving.
- Used to check divider outputs in-system and to qualify downstream logic.

---
 rtl/period_meter.sv | 189 ++++++++++++++++++
 tb/tb_period_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures the period of a slow asynchronous square wave in clk cycles,
// reports each period with a strobe, and tracks lock and timeout status.
module period_meter #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1023,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_V     = CNT_W'(TOL);
  localparam logic [3:0]       LOCK_V    = 4'(LOCK_CNT);

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  state_t           state_r, state_s;
  logic             s1_r, s2_r, s3_r;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       match_cnt_r, match_cnt_s;
  logic [CNT_W-1:0] prev_period_r, prev_period_s;
  logic             first_r, first_s;
  logic [CNT_W-1:0] period_r, period_s;
  logic             period_valid_r, period_valid_s;
  logic             locked_r, locked_s;
  logic             timeout_r, timeout_s;

  logic             rise_s;
  logic             timeout_hit_s;
  logic             in_tol_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [3:0]       match_inc_s;
  logic [3:0]       match_new_s;

  assign rise_s        = s2_r & ~s3_r;
  assign timeout_hit_s = (cnt_r >= TIMEOUT_V);
  assign cnt_inc_s     = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
  assign in_tol_s      = (abs_diff(cnt_r, prev_period_r) <= TOL_V);
  assign match_inc_s   = (match_cnt_r >= LOCK_V) ? LOCK_V : match_cnt_r + 4'd1;
  // The first period after arming has no predecessor to compare against.
  assign match_new_s   = first_r ? 4'd0 : (in_tol_s ? match_inc_s : 4'd0);

  // Synchronizer and edge-detect flops; free-running regardless of en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath decisions; en=0 overrides rise and timeout.
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    match_cnt_s    = match_cnt_r;
    prev_period_s  = prev_period_r;
    first_s        = first_r;
    period_s       = period_r;
    period_valid_s = 1'b0;
    locked_s       = locked_r;
    timeout_s      = timeout_r;
    if (!en) begin
      state_s     = IDLE;
      cnt_s       = '0;
      match_cnt_s = 4'd0;
      first_s     = 1'b1;
      locked_s    = 1'b0;
      timeout_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s     = ARM;
          cnt_s       = '0;
          match_cnt_s = 4'd0;
          first_s     = 1'b1;
          locked_s    = 1'b0;
          timeout_s   = 1'b0;
        end
        ARM: begin
          if (rise_s) begin
            state_s = MEAS;
            cnt_s   = CNT_W'(1);
            first_s = 1'b1;
          end else if (timeout_hit_s) begin
            cnt_s       = '0;
            match_cnt_s = 4'd0;
            locked_s    = 1'b0;
            timeout_s   = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        MEAS: begin
          if (rise_s) begin
            period_s       = cnt_r;
            prev_period_s  = cnt_r;
            period_valid_s = 1'b1;
            cnt_s          = CNT_W'(1);
            first_s        = 1'b0;
            match_cnt_s    = match_new_s;
            locked_s       = (match_new_s == LOCK_V);
            timeout_s      = 1'b0;
          end else if (timeout_hit_s) begin
            state_s     = ARM;
            cnt_s       = '0;
            match_cnt_s = 4'd0;
            locked_s    = 1'b0;
            timeout_s   = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        default: begin
          state_s     = IDLE;
          cnt_s       = '0;
          match_cnt_s = 4'd0;
          first_s     = 1'b1;
          locked_s    = 1'b0;
          timeout_s   = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r          <= '0;
      match_cnt_r    <= 4'd0;
      prev_period_r  <= '0;
      first_r        <= 1'b1;
      period_r       <= '0;
      period_valid_r <= 1'b0;
      locked_r       <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      cnt_r          <= cnt_s;
      match_cnt_r    <= match_cnt_s;
      prev_period_r  <= prev_period_s;
      first_r        <= first_s;
      period_r       <= period_s;
      period_valid_r <= period_valid_s;
      locked_r       <= locked_s;
      timeout_r      <= timeout_s;
    end
  end

  assign period       = period_r;
  assign period_valid = period_valid_r;
  assign locked       = locked_r;
  assign timeout      = timeout_r;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: table of sig_in periods with expected
// strobes, plus hand sequences for timeout, enable drop and reset.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sig_in;
  logic [15:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int   hi;
    int   lo;
    logic v;
    int   per;
    logic lk;
    logic to;
  } vec_t;

  typedef struct {
    int   per;
    logic lk;
    logic to;
  } obs_t;

  vec_t vec [32];
  obs_t obs_q [$];
  obs_t mon_o;

  always #5 clk = ~clk;

  period_meter dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  // Record every strobe with the status sampled alongside it.
  always @(negedge clk) begin
    if (period_valid) begin
      mon_o.per = int'(period);
      mon_o.lk  = locked;
      mon_o.to  = timeout;
      obs_q.push_back(mon_o);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input int i, input int hi, input int lo, input logic v,
                     input int per, input logic lk);
    vec[i].hi  = hi;
    vec[i].lo  = lo;
    vec[i].v   = v;
    vec[i].per = per;
    vec[i].lk  = lk;
    vec[i].to  = 1'b0;
  endtask

  // Called #1 after a posedge; rise-to-rise spacing equals hi+lo cycles.
  task automatic drive_period(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1 sig_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string name, input int per, input logic lk, input logic to);
    obs_t o;
    if (obs_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no period_valid seen, expected period %0d", name, per);
    end else begin
      o = obs_q.pop_front();
      chk({name, "_period"}, o.per, per);
      chk({name, "_locked"}, int'(o.lk), int'(lk));
      chk({name, "_timeout"}, int'(o.to), int'(to));
    end
  endtask

  task automatic run_seg(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive_period(vec[i].hi, vec[i].lo);
    end
  endtask

  task automatic check_seg(input string name, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (vec[i].v) begin
        pop_chk($sformatf("%s_v%0d", name, i), vec[i].per, vec[i].lk, vec[i].to);
      end
    end
    chk({name, "_extra_valids"}, obs_q.size(), 0);
  endtask

  initial begin
    // Divide-by-8 lock, then 9/8/9 jitter, a 12 outlier and relock.
    put(0, 4, 4, 1'b0, 0, 1'b0);
    put(1, 4, 4, 1'b1, 8, 1'b0);
    put(2, 4, 4, 1'b1, 8, 1'b0);
    put(3, 4, 4, 1'b1, 8, 1'b0);
    put(4, 4, 4, 1'b1, 8, 1'b0);
    put(5, 5, 4, 1'b1, 8, 1'b1);
    put(6, 4, 4, 1'b1, 9, 1'b1);
    put(7, 5, 4, 1'b1, 8, 1'b1);
    put(8, 6, 6, 1'b1, 9, 1'b1);
    put(9, 4, 4, 1'b1, 12, 1'b0);
    put(10, 4, 4, 1'b1, 8, 1'b0);
    put(11, 4, 4, 1'b1, 8, 1'b0);
    put(12, 4, 4, 1'b1, 8, 1'b0);
    put(13, 4, 4, 1'b1, 8, 1'b0);
    put(14, 4, 4, 1'b1, 8, 1'b1);
    // After timeout: reference edge, then period-2 lock, then back to 8.
    put(15, 1, 1, 1'b0, 0, 1'b0);
    put(16, 1, 1, 1'b1, 2, 1'b0);
    put(17, 1, 1, 1'b1, 2, 1'b0);
    put(18, 1, 1, 1'b1, 2, 1'b0);
    put(19, 1, 1, 1'b1, 2, 1'b0);
    put(20, 4, 4, 1'b1, 2, 1'b1);
    put(21, 4, 4, 1'b1, 8, 1'b0);
    put(22, 4, 4, 1'b1, 8, 1'b0);
    put(23, 4, 4, 1'b1, 8, 1'b0);
    put(24, 4, 4, 1'b1, 8, 1'b0);
    put(25, 4, 4, 1'b1, 8, 1'b1);
    // After enable drop: reference edge, then lock again at 8.
    put(26, 4, 4, 1'b0, 0, 1'b0);
    put(27, 4, 4, 1'b1, 8, 1'b0);
    put(28, 4, 4, 1'b1, 8, 1'b0);
    put(29, 4, 4, 1'b1, 8, 1'b0);
    put(30, 4, 4, 1'b1, 8, 1'b0);
    put(31, 4, 4, 1'b1, 8, 1'b1);

    rst    = 1'b0;
    en     = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    en = 1'b1;

    run_seg(0, 14);
    check_seg("lock8", 0, 14);

    // Last edge, then hold low until the timeout fires.
    sig_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 sig_in = 1'b0;
    repeat (1021) @(posedge clk);
    @(negedge clk);
    chk("pre_to_timeout", int'(timeout), 0);
    chk("pre_to_locked", int'(locked), 1);
    @(posedge clk);
    @(negedge clk);
    chk("to_timeout", int'(timeout), 1);
    chk("to_locked", int'(locked), 0);
    pop_chk("to_last", 8, 1'b1, 1'b0);
    chk("to_extra_valids", obs_q.size(), 0);
    @(posedge clk);
    #1;

    run_seg(15, 25);
    check_seg("p2", 15, 25);

    // Drop enable mid-period for three cycles.
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("dis_locked", int'(locked), 0);
    chk("dis_timeout", int'(timeout), 0);
    chk("dis_period", int'(period), 8);
    chk("dis_valid", int'(period_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1 en = 1'b1;
    run_seg(26, 31);
    check_seg("reen", 26, 31);

    // Reset while locked, then repeat the divide-by-8 bring-up.
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_valid", int'(period_valid), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_timeout", int'(timeout), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_seg(0, 5);
    check_seg("after_rst", 0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
